// File: rtl/alu_input_seq.sv
// alu_input_seq: turns a bouncy push button and four switches into the
// operand/opcode set for a downstream ALU. Each accepted press latches the
// switches into the next field: A, then B, then the opcode. The press
// after that clears valid and the sequence starts again.
module alu_input_seq #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] op,
    output logic       valid,
    output logic [1:0] stage,
    output logic       press
);

    // The counter never holds a value above DEBOUNCE_CYCLES-1, so
    // clog2 bits are enough and the counter cannot wrap.
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    logic          sync1_r;
    logic          sync2_r;
    logic          db_level_r;
    logic          db_prev_r;
    logic [CW-1:0] cnt_r;
    logic          rise_s;

    state_t        state_r;
    state_t        state_next_s;
    logic [3:0]    a_next_s;
    logic [3:0]    b_next_s;
    logic [2:0]    op_next_s;
    logic          valid_next_s;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept a new level only after it has been seen for
    // DEBOUNCE_CYCLES consecutive samples; any return to the old level
    // restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_level_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else if (sync2_r == db_level_r) begin
            cnt_r      <= CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            db_level_r <= sync2_r;
            cnt_r      <= CNT_ZERO;
        end else begin
            cnt_r      <= cnt_r + CNT_ONE;
        end
    end

    // A press is a rising edge of the debounced level. Releases are ignored.
    assign rise_s = db_level_r & ~db_prev_r;

    // Registered one-cycle press pulse, one edge after the debounced rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev_r <= 1'b0;
            press     <= 1'b0;
        end else begin
            db_prev_r <= db_level_r;
            press     <= rise_s;
        end
    end

    // Next state and next operand values. Fields change only on a press.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = A;
        b_next_s     = B;
        op_next_s    = op;
        valid_next_s = valid;
        if (press) begin
            case (state_r)
                S_A: begin
                    a_next_s     = sw;
                    state_next_s = S_B;
                end
                S_B: begin
                    b_next_s     = sw;
                    state_next_s = S_OP;
                end
                S_OP: begin
                    // Only three opcode bits exist, so sw[3] is dropped.
                    op_next_s    = sw[2:0];
                    valid_next_s = 1'b1;
                    state_next_s = S_SHOW;
                end
                S_SHOW: begin
                    valid_next_s = 1'b0;
                    state_next_s = S_A;
                end
                default: begin
                    valid_next_s = 1'b0;
                    state_next_s = S_A;
                end
            endcase
        end else begin
            state_next_s = state_r;
            valid_next_s = valid;
        end
    end

    // State and latched operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_A;
            A       <= 4'd0;
            B       <= 4'd0;
            op      <= 3'd0;
            valid   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            A       <= a_next_s;
            B       <= b_next_s;
            op      <= op_next_s;
            valid   <= valid_next_s;
        end
    end

    assign stage = state_r;

endmodule

// File: tb/tb_alu_input_seq.sv
// Self-checking bench for alu_input_seq. It uses a table of clean presses,
// hand-written bounce, glitch and reset sequences, and randomized button and
// switch activity. Every cycle is compared against an event-level
// reference model.
module tb_alu_input_seq;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic       valid;
    logic [1:0] stage;
    logic       press;

    alu_input_seq #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .btn   (btn),
        .A     (A),
        .B     (B),
        .op    (op),
        .valid (valid),
        .stage (stage),
        .press (press)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic       m_pipe[$];   // btn samples not yet visible after synchronization
    logic       m_win[$];    // recent synchronized samples since the last level change
    logic       m_lvl;
    logic       m_rose;
    logic       m_press;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_op;
    logic       m_valid;
    int         m_stage;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       valid;
        logic [1:0] stage;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe  = {1'b0, 1'b0};
        m_win   = {};
        m_lvl   = 1'b0;
        m_rose  = 1'b0;
        m_press = 1'b0;
        m_a     = 4'd0;
        m_b     = 4'd0;
        m_op    = 3'd0;
        m_valid = 1'b0;
        m_stage = 0;
    endtask

    // Advance the model by one rising edge. b and s are the inputs at that edge.
    task automatic model_step(input logic b, input logic [3:0] s);
        logic bs;
        bit   all_diff;
        logic rise_now;
        if (m_press) begin
            case (m_stage)
                0: m_a = s;
                1: m_b = s;
                2: begin m_op = s[2:0]; m_valid = 1'b1; end
                default: m_valid = 1'b0;
            endcase
            m_stage = (m_stage + 1) % 4;
        end
        m_press = m_rose;
        bs = m_pipe.pop_front();
        m_pipe.push_back(b);
        m_win.push_back(bs);
        if (m_win.size() > D) m_win.delete(0);
        all_diff = (m_win.size() == D);
        foreach (m_win[i]) if (m_win[i] == m_lvl) all_diff = 1'b0;
        rise_now = 1'b0;
        if (all_diff) begin
            m_lvl    = ~m_lvl;
            rise_now = m_lvl;
            m_win    = {};
        end
        m_rose = rise_now;
    endtask

    task automatic check_model();
        checks++;
        if (A !== m_a || B !== m_b || op !== m_op || valid !== m_valid ||
            stage !== 2'(m_stage) || press !== m_press) begin
            errors++;
            $display("FAIL model t=%0t actual A=%0d B=%0d op=%0d valid=%0b stage=%0d press=%0b expected A=%0d B=%0d op=%0d valid=%0b stage=%0d press=%0b",
                     $time, A, B, op, valid, stage, press,
                     m_a, m_b, m_op, m_valid, m_stage, m_press);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(btn, sw);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_press(input logic [3:0] s);
        sw  = s;
        btn = 1'b1;
        repeat (D + 5) tick();
        btn = 1'b0;
        repeat (D + 5) tick();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int press_cnt;
        int first_at;
        int len;
        int stage_before;

        tbl[0] = '{4'd3,  4'd3, 4'd0, 3'd0, 1'b0, 2'd1};
        tbl[1] = '{4'd5,  4'd3, 4'd5, 3'd0, 1'b0, 2'd2};
        tbl[2] = '{4'd6,  4'd3, 4'd5, 3'd6, 1'b1, 2'd3};
        tbl[3] = '{4'd10, 4'd3, 4'd5, 3'd6, 1'b0, 2'd0};
        tbl[4] = '{4'd9,  4'd9, 4'd5, 3'd6, 1'b0, 2'd1};
        tbl[5] = '{4'd7,  4'd9, 4'd7, 3'd6, 1'b0, 2'd2};
        tbl[6] = '{4'd15, 4'd9, 4'd7, 3'd7, 1'b1, 2'd3};
        tbl[7] = '{4'd0,  4'd9, 4'd7, 3'd7, 1'b0, 2'd0};

        rst = 1'b1;
        btn = 1'b0;
        sw  = 4'd0;
        model_reset();
        tick();
        tick();
        chk("reset_A", int'(A), 0);
        chk("reset_B", int'(B), 0);
        chk("reset_op", int'(op), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_stage", int'(stage), 0);
        chk("reset_press", int'(press), 0);
        rst = 1'b0;
        tick();

        // Clean presses, including opcode masking and wrap-around.
        for (int i = 0; i < 8; i++) begin
            do_press(tbl[i].sw);
            chk($sformatf("tbl%0d_A", i), int'(A), int'(tbl[i].a));
            chk($sformatf("tbl%0d_B", i), int'(B), int'(tbl[i].b));
            chk($sformatf("tbl%0d_op", i), int'(op), int'(tbl[i].op));
            chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d_stage", i), int'(stage), int'(tbl[i].stage));
        end

        // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
        press_cnt = 0;
        first_at  = -1;
        sw = 4'd1;
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 0);
            tick();
            if (press) press_cnt++;
        end
        btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press) begin
                press_cnt++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("bounce_press_count", press_cnt, 1);
        chk("bounce_latency", first_at, 7);
        chk("bounce_A", int'(A), 1);
        btn = 1'b0;
        repeat (D + 5) tick();

        // Glitch: three cycles high is shorter than the debounce window.
        stage_before = m_stage;
        press_cnt = 0;
        btn = 1'b1;
        repeat (3) begin tick(); if (press) press_cnt++; end
        btn = 1'b0;
        repeat (10) begin tick(); if (press) press_cnt++; end
        chk("glitch_press_count", press_cnt, 0);
        chk("glitch_stage", int'(stage), stage_before);

        // Reset in S_OP with A=2, B=7.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        do_press(4'd2);
        do_press(4'd7);
        chk("pre_reset_stage", int'(stage), 2);
        chk("pre_reset_B", int'(B), 7);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_A", int'(A), 0);
        chk("async_reset_B", int'(B), 0);
        chk("async_reset_op", int'(op), 0);
        chk("async_reset_valid", int'(valid), 0);
        chk("async_reset_stage", int'(stage), 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_stage", int'(stage), 0);
        do_press(4'd4);
        chk("post_reset_first_A", int'(A), 4);
        chk("post_reset_stage1", int'(stage), 1);

        // Button held high across reset release becomes a press that loads A.
        sw  = 4'd12;
        btn = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (D + 6) tick();
        chk("held_across_reset_A", int'(A), 12);
        chk("held_across_reset_stage", int'(stage), 1);
        btn = 1'b0;
        repeat (D + 5) tick();

        // Random button runs and switch values, with occasional resets.
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            btn = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                sw = 4'($urandom_range(0, 15));
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
